// File: rtl/vnlp_pkg.sv
// Shared types and constants for the vector-norm linked-list processor.
// Imported by the engine and its accumulator sub-module.
package vnlp_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ISSUE  = 2'd1,
      WAIT   = 2'd2,
      DONE_S = 2'd3
   } state_e;

   localparam logic MODE_L2SQ = 1'b0;
   localparam logic MODE_L1   = 1'b1;

endpackage

// File: rtl/vnlp_if.sv
// Start/done handshake plus dual read-port memory bus of the norm engine.
// master = engine side, slave = controller/memory side.
interface vnlp_if #(
   parameter int DW   = 24,
   parameter int AW   = 9,
   parameter int ACCW = 2*DW-1,
   parameter int LW   = 7
);
   logic            START;
   logic [AW-1:0]   HEAD;
   logic            NORM_MODE;
   logic [AW-1:0]   rd_addr1;
   logic [AW-1:0]   rd_addr2;
   logic [DW-1:0]   rd_data1;
   logic [DW-1:0]   rd_data2;
   logic            DONE;
   logic [ACCW-1:0] NORM2;
   logic [LW-1:0]   LEN;
   logic            ERR;
   logic            SAT;

   modport master (
      input  START, HEAD, NORM_MODE, rd_data1, rd_data2,
      output rd_addr1, rd_addr2, DONE, NORM2, LEN, ERR, SAT
   );

   modport slave (
      output START, HEAD, NORM_MODE, rd_data1, rd_data2,
      input  rd_addr1, rd_addr2, DONE, NORM2, LEN, ERR, SAT
   );
endinterface

// File: rtl/vnlp_mac.sv
// Registered per-element term (square or magnitude) feeding a saturating
// unsigned accumulator with a sticky saturation flag.
module vnlp_mac
   import vnlp_pkg::*;
#(
   parameter int DW   = 24,
   parameter int ACCW = 2*DW-1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 clear_i,
   input  logic                 en_i,
   input  logic                 mode_i,
   input  logic signed [DW-1:0] data_i,
   output logic [ACCW-1:0]      acc_o,
   output logic                 sat_o
);

   localparam int TW = 2*DW;
   localparam int SW = (ACCW + 1 > TW) ? ACCW + 1 : TW + 1;

   logic [TW-1:0]   term_d, term_p1_q;
   logic            vld_p1_q;
   logic [ACCW-1:0] acc_q, acc_d;
   logic            sat_q, sat_d;

   function automatic logic [TW-1:0] f_square(input logic signed [DW-1:0] x);
      logic signed [TW-1:0] xe;
      xe = TW'(x);
      return $unsigned(xe * xe);
   endfunction

   // Widened by one bit so the most negative input has a representable magnitude.
   function automatic logic [TW-1:0] f_abs(input logic signed [DW-1:0] x);
      logic signed [DW:0] xe;
      xe = (DW+1)'(x);
      if (xe < 0) xe = -xe;
      return TW'($unsigned(xe));
   endfunction

   function automatic logic [SW-1:0] f_sum(input logic [ACCW-1:0] a,
                                           input logic [TW-1:0]   t);
      return SW'(a) + SW'(t);
   endfunction

   always_comb begin
      logic [SW-1:0] sum;
      term_d = '0;
      unique case (mode_i)
         MODE_L2SQ: term_d = f_square(data_i);
         MODE_L1:   term_d = f_abs(data_i);
         default:   term_d = '0;
      endcase
      acc_d = acc_q;
      sat_d = sat_q;
      sum   = f_sum(acc_q, term_p1_q);
      if (vld_p1_q && !sat_q) begin
         if (|sum[SW-1:ACCW]) begin
            acc_d = '1;
            sat_d = 1'b1;
         end else begin
            acc_d = sum[ACCW-1:0];
         end
      end
   end

   // p1: registered term, then accumulate on the following edge
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         term_p1_q <= '0;
         vld_p1_q  <= 1'b0;
         acc_q     <= '0;
         sat_q     <= 1'b0;
      end else if (clear_i) begin
         term_p1_q <= '0;
         vld_p1_q  <= 1'b0;
         acc_q     <= '0;
         sat_q     <= 1'b0;
      end else begin
         term_p1_q <= term_d;
         vld_p1_q  <= en_i;
         acc_q     <= acc_d;
         sat_q     <= sat_d;
      end
   end

   assign acc_o = acc_q;
   assign sat_o = sat_q;

endmodule

// File: rtl/vnlp_engine.sv
// Walks a circular linked list in external memory and accumulates the squared
// L2 or the L1 norm of all node elements, counting the nodes visited.
module vnlp_engine
   import vnlp_pkg::*;
#(
   parameter int DW      = 24,
   parameter int AW      = 9,
   parameter int NELEM   = 1,
   parameter int LW      = 7,
   parameter int ACCW    = 2*DW-1,
   parameter int LEN_MAX = 2**LW-1
) (
   input  logic   clk,
   input  logic   rst_n,
   vnlp_if.master bus
);

   localparam int KW = (NELEM > 1) ? $clog2(NELEM) : 1;

   state_e          state_q, state_d;
   logic [AW-1:0]   head_q, head_d;
   logic [AW-1:0]   addr1_q, addr1_d;
   logic [AW-1:0]   addr2_q, addr2_d;
   logic            mode_q, mode_d;
   logic [KW-1:0]   k_q, k_d;
   logic [LW-1:0]   len_q, len_d;
   logic            err_q, err_d;
   logic            done_q, done_d;
   logic            ivld_q;
   logic            start_ok;
   logic [AW-1:0]   link;
   logic [ACCW-1:0] acc;
   logic            sat;
   logic signed [DW-1:0] elem;

   assign link = bus.rd_data1[AW-1:0];
   assign elem = bus.rd_data2;

   generate
      if (DW > AW) begin : g_link_pad
         logic unused_link_hi;
         assign unused_link_hi = ^bus.rd_data1[DW-1:AW];
      end
   endgenerate

   always_comb begin
      state_d  = state_q;
      head_d   = head_q;
      addr1_d  = addr1_q;
      addr2_d  = addr2_q;
      mode_d   = mode_q;
      k_d      = k_q;
      len_d    = len_q;
      err_d    = err_q;
      done_d   = done_q;
      start_ok = 1'b0;
      unique case (state_q)
         IDLE, DONE_S: begin
            if (bus.START) begin
               start_ok = 1'b1;
               head_d   = bus.HEAD;
               mode_d   = bus.NORM_MODE;
               addr1_d  = bus.HEAD;
               addr2_d  = bus.HEAD + 1'b1;
               k_d      = '0;
               len_d    = '0;
               err_d    = 1'b0;
               done_d   = 1'b0;
               state_d  = ISSUE;
            end else if (state_q == DONE_S) begin
               // One cycle after entry the last term has reached the accumulator.
               done_d = 1'b1;
            end
         end
         ISSUE: begin
            if (k_q == KW'(NELEM-1)) begin
               state_d = WAIT;
            end else begin
               k_d     = k_q + 1'b1;
               addr2_d = addr2_q + 1'b1;
            end
         end
         WAIT: begin
            len_d = len_q + 1'b1;
            if (link == head_q) begin
               err_d   = 1'b0;
               state_d = DONE_S;
            end else if (({1'b0, len_q} + 1'b1) == (LW+1)'(LEN_MAX)) begin
               err_d   = 1'b1;
               state_d = DONE_S;
            end else begin
               k_d     = '0;
               addr1_d = link;
               addr2_d = link + 1'b1;
               state_d = ISSUE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         head_q  <= '0;
         addr1_q <= '0;
         addr2_q <= '0;
         mode_q  <= MODE_L2SQ;
         k_q     <= '0;
         len_q   <= '0;
         err_q   <= 1'b0;
         done_q  <= 1'b0;
         ivld_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         head_q  <= head_d;
         addr1_q <= addr1_d;
         addr2_q <= addr2_d;
         mode_q  <= mode_d;
         k_q     <= k_d;
         len_q   <= len_d;
         err_q   <= err_d;
         done_q  <= done_d;
         // Element data is on rd_data2 the cycle after its address was issued.
         ivld_q  <= (state_q == ISSUE);
      end
   end

   vnlp_mac #(
      .DW   (DW),
      .ACCW (ACCW)
   ) u_mac (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear_i (start_ok),
      .en_i    (ivld_q),
      .mode_i  (mode_q),
      .data_i  (elem),
      .acc_o   (acc),
      .sat_o   (sat)
   );

   assign bus.rd_addr1 = addr1_q;
   assign bus.rd_addr2 = addr2_q;
   assign bus.DONE     = done_q;
   assign bus.NORM2    = acc;
   assign bus.LEN      = len_q;
   assign bus.ERR      = err_q;
   assign bus.SAT      = sat;

endmodule

// File: tb/tb_vnlp_engine.sv
// Self-checking bench: three engine configurations share one memory image;
// a vector table drives runs and a scoreboard holds the expected results.
module tb_vnlp_engine;

   typedef struct {
      int          sel;
      logic [8:0]  head;
      logic        mode;
      int          pulse;
      logic [46:0] norm2;
      logic [6:0]  len;
      logic        err;
      logic        sat;
      int          dn;
   } vec_t;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [8:0]  head;
   logic        mode;
   int          sel;
   logic [23:0] mem [0:511];

   logic        done, err, sat;
   logic [46:0] norm2;
   logic [6:0]  len;
   logic [8:0]  a1, a2;

   int   n_pass = 0;
   int   n_tot  = 0;
   vec_t vecs [7];
   vec_t sb [$];

   vnlp_if #(.DW(24), .AW(9), .ACCW(47), .LW(7)) if0 ();
   vnlp_if #(.DW(24), .AW(9), .ACCW(47), .LW(7)) if1 ();
   vnlp_if #(.DW(24), .AW(9), .ACCW(47), .LW(7)) if2 ();

   vnlp_engine u_dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
   vnlp_engine #(.NELEM(2)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
   vnlp_engine #(.LEN_MAX(4)) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(if2));

   assign if0.START = start && (sel == 0);
   assign if1.START = start && (sel == 1);
   assign if2.START = start && (sel == 2);
   assign if0.HEAD = head;  assign if0.NORM_MODE = mode;
   assign if1.HEAD = head;  assign if1.NORM_MODE = mode;
   assign if2.HEAD = head;  assign if2.NORM_MODE = mode;

   always @(posedge clk) begin
      if0.rd_data1 <= mem[if0.rd_addr1];
      if0.rd_data2 <= mem[if0.rd_addr2];
      if1.rd_data1 <= mem[if1.rd_addr1];
      if1.rd_data2 <= mem[if1.rd_addr2];
      if2.rd_data1 <= mem[if2.rd_addr1];
      if2.rd_data2 <= mem[if2.rd_addr2];
   end

   always_comb begin
      case (sel)
         1: begin
            done = if1.DONE; norm2 = if1.NORM2; len = if1.LEN; err = if1.ERR;
            sat = if1.SAT; a1 = if1.rd_addr1; a2 = if1.rd_addr2;
         end
         2: begin
            done = if2.DONE; norm2 = if2.NORM2; len = if2.LEN; err = if2.ERR;
            sat = if2.SAT; a1 = if2.rd_addr1; a2 = if2.rd_addr2;
         end
         default: begin
            done = if0.DONE; norm2 = if0.NORM2; len = if0.LEN; err = if0.ERR;
            sat = if0.SAT; a1 = if0.rd_addr1; a2 = if0.rd_addr2;
         end
      endcase
   end

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got running want finished");
      $fatal(1);
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_tot++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0d want %0d", nm, act, exp);
   endtask

   task automatic chk_zero_outputs(input string tag);
      chk({tag, "_done"},  done,  0);
      chk({tag, "_norm2"}, norm2, 0);
      chk({tag, "_len"},   len,   0);
      chk({tag, "_err"},   err,   0);
      chk({tag, "_sat"},   sat,   0);
      chk({tag, "_addr1"}, a1,    0);
      chk({tag, "_addr2"}, a2,    0);
   endtask

   task automatic run_vec(input vec_t v);
      vec_t       e;
      int         n;
      logic [8:0] h1;
      h1 = v.head + 9'd1;
      @(negedge clk);
      sel   = v.sel;
      head  = v.head;
      mode  = v.mode;
      start = 1'b1;
      sb.push_back(v);
      @(posedge clk); #1;
      start = 1'b0;
      n = 0;
      chk("done_drop", done, 0);
      chk("norm2_clr", norm2, 0);
      chk("len_clr", len, 0);
      chk("addr1_head", a1, v.head);
      chk("addr2_elem", a2, h1);
      while (!done && n < 200) begin
         @(posedge clk); #1;
         n++;
         if (v.pulse != 0 && n + 1 == v.pulse) begin
            start = 1'b1;
            head  = 9'h060;
         end else begin
            start = 1'b0;
         end
      end
      start = 1'b0;
      e = sb.pop_front();
      chk("done_seen", done, 1);
      chk("done_edge", n, e.dn);
      chk("norm2", norm2, e.norm2);
      chk("len", len, e.len);
      chk("err", err, e.err);
      chk("sat", sat, e.sat);
      repeat (2) @(posedge clk);
      #1;
      chk("done_hold", done, 1);
      chk("norm2_hold", norm2, e.norm2);
   endtask

   initial begin
      rst_n = 1'b0;
      start = 1'b0;
      head  = '0;
      mode  = 1'b0;
      sel   = 0;

      for (int i = 0; i < 512; i++) mem[i] = 24'h0;
      // ring 0 -> 5 -> 9 -> 0, link words carry junk above the address bits
      mem[0]  = 24'h000005; mem[1]  = 24'd3;
      mem[5]  = 24'hABC009; mem[6]  = 24'hFFFFFC;
      mem[9]  = 24'h7F0000; mem[10] = 24'd12;
      mem[16] = 24'h000010; mem[17] = 24'hFFFFFF;
      mem[32] = 24'h000030; mem[33] = 24'd5;      mem[34] = 24'hFFFFF9;
      mem[48] = 24'h000020; mem[49] = 24'h800000; mem[50] = 24'd1;
      for (int i = 0; i < 6; i++) begin
         mem[64 + 2*i] = (i == 5) ? 24'd64 : 24'(66 + 2*i);
         mem[65 + 2*i] = 24'd1;
      end
      mem[96] = 24'h000062; mem[97] = 24'h800000;
      mem[98] = 24'h000060; mem[99] = 24'h800000;

      //            sel head    mode  pulse norm2                   len err sat edge
      vecs[0] = '{0, 9'h000, 1'b0, 0, 47'd169,                 7'd3, 1'b0, 1'b0, 7};
      vecs[1] = '{0, 9'h010, 1'b0, 0, 47'd1,                   7'd1, 1'b0, 1'b0, 3};
      vecs[2] = '{1, 9'h020, 1'b1, 0, 47'd8388621,             7'd2, 1'b0, 1'b0, 7};
      vecs[3] = '{2, 9'h040, 1'b0, 0, 47'd4,                   7'd4, 1'b1, 1'b0, 9};
      vecs[4] = '{0, 9'h060, 1'b0, 0, 47'h7FFF_FFFF_FFFF,      7'd2, 1'b0, 1'b1, 5};
      vecs[5] = '{0, 9'h000, 1'b1, 3, 47'd19,                  7'd3, 1'b0, 1'b0, 7};
      vecs[6] = '{0, 9'h060, 1'b1, 0, 47'd16777216,            7'd2, 1'b0, 1'b0, 5};

      repeat (3) @(posedge clk);
      #1;
      chk_zero_outputs("reset");
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 7; i++) run_vec(vecs[i]);

      // Asynchronous reset while the second node is being fetched.
      @(negedge clk);
      sel   = 0;
      head  = 9'h000;
      mode  = 1'b0;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("midrun_addr1", a1, 9'd5);
      chk("midrun_len", len, 1);
      rst_n = 1'b0;
      #1;
      chk_zero_outputs("async_rst");
      @(negedge clk);
      rst_n = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      chk("idle_done", done, 0);
      chk("idle_len", len, 0);

      run_vec(vecs[0]);

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
